// File: rtl/rlc_pio_bank_if.sv
// Avalon-MM slave port bundle for rlc_pio_bank.
// The bus fabric side uses master; the PIO bank uses slave.
interface rlc_pio_bank_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );
endinterface

// File: rtl/rlc_pio_bank.sv
// Parametrised PIO bank: synchronised and debounced inputs with edge capture and interrupt,
// plus a registered output port with atomic set/clear, all behind an Avalon-MM slave.
module rlc_pio_bank #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       DEBOUNCE_CYC = 16,
  parameter int unsigned       EDGE_MODE    = 0,
  parameter logic [DATA_W-1:0] OUT_RESET    = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  rlc_pio_bank_if.slave     avs,
  input  logic [DATA_W-1:0] pins_in,
  output logic [DATA_W-1:0] pins_out,
  output logic              irq
);

  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_addr_e;

  reg_addr_e         addr;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] sync1, sync2;
  logic [1:0]        sync_ok;
  logic [DATA_W-1:0] db_q, db_next, qual;
  logic [DATA_W-1:0] armed, edge_cap, irq_mask;
  logic [DATA_W-1:0] edge_sel, new_edge, w1c, out_next, mask_next;
  logic [31:0]       rd_word, readdata;
  logic              unused_bits;

  assign addr             = reg_addr_e'(avs.avs_address);
  assign wd               = avs.avs_writedata[DATA_W-1:0];
  assign avs.avs_readdata = readdata;
  assign unused_bits      = ^{avs.avs_writedata, sync_ok, sync2};

  // sync_ok tracks how many synchroniser stages hold real pin samples since reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync_ok <= '0;
    end else begin
      sync1   <= pins_in;
      sync2   <= sync1;
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      // db_q mirrors sync2; qualifying on sync1 lets edges be seen at the same edge sync2 moves
      assign db_next = sync1;
      assign qual    = {DATA_W{sync_ok[0]}};
    end else begin : g_debounce
      localparam int unsigned      CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

      logic [CNT_W-1:0] cnt [DATA_W];

      // sync2 is the candidate; a pending change in sync1 restarts the hold count
      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          for (int unsigned i = 0; i < DATA_W; i++) cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (sync1[i] != sync2[i])  cnt[i] <= '0;
            else if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end

      always_comb begin
        qual = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
          qual[i] = sync_ok[1] && (sync1[i] == sync2[i]) && (cnt[i] == CNT_MAX);
      end

      assign db_next = sync2;
    end
  endgenerate

  always_comb begin
    edge_sel = '0;
    if (EDGE_MODE == 0)      edge_sel = qual & db_next & ~db_q;
    else if (EDGE_MODE == 1) edge_sel = qual & ~db_next & db_q;
    else                     edge_sel = qual & (db_next ^ db_q);
    new_edge = edge_sel & armed;
  end

  always_comb begin
    out_next  = pins_out;
    mask_next = irq_mask;
    w1c       = '0;
    if (avs.avs_write) begin
      case (addr)
        REG_OUT:     out_next  = wd;
        REG_IRQMASK: mask_next = wd;
        REG_EDGECAP: w1c       = wd;
        REG_OUTSET:  out_next  = pins_out | wd;
        REG_OUTCLR:  out_next  = pins_out & ~wd;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      REG_IN:      rd_word[DATA_W-1:0] = db_q;
      REG_OUT:     rd_word[DATA_W-1:0] = pins_out;
      REG_IRQMASK: rd_word[DATA_W-1:0] = irq_mask;
      REG_EDGECAP: rd_word[DATA_W-1:0] = edge_cap;
      default:     rd_word = '0;
    endcase
  end

  // W1C and a fresh edge on the same bit: the OR after the clear keeps the edge
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      db_q     <= '0;
      armed    <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      pins_out <= OUT_RESET;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      db_q     <= (qual & db_next) | (~qual & db_q);
      armed    <= armed | qual;
      edge_cap <= (edge_cap & ~w1c) | new_edge;
      irq_mask <= mask_next;
      pins_out <= out_next;
      irq      <= |(edge_cap & irq_mask);
      if (avs.avs_read) readdata <= rd_word;
    end
  end

endmodule
